// File: rtl/stream_pack_if.sv
// stream: single-direction valid/ready stream carrying one value of type T.
//   send    - producer side: drives valid/data, observes ready.
//   receive - consumer side: observes valid/data, drives ready.
interface stream #(
    parameter type T = logic [31:0]
) ();
    T     data;
    logic valid;
    logic ready;

    modport send    (output valid, output data, input  ready);
    modport receive (input  valid, input  data, output ready);
endinterface

// File: rtl/stream_pack.sv
// stream_pack: packs RATIO narrow beats into one wide word.
//   clock, reset - clock and synchronous active-high reset.
//   receiver     - narrow input beats (type T), lane 0 = first beat.
//   sender       - packed words, RATIO*$bits(T) wide.
//   flush        - one-cycle request to emit the current partial word.
//   lanes        - count of valid lanes in sender.data, registered with it.
// Partial words also go out after TIMEOUT idle cycles (0 disables this).
module stream_pack #(
    parameter type T       = logic [31:0],
    parameter int  RATIO   = 4,
    parameter int  TIMEOUT = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    stream.receive                     receiver,
    stream.send                        sender,
    input  logic                       flush,
    output logic [$clog2(RATIO):0]     lanes
);
    localparam int W  = $bits(T);
    localparam int FW = $clog2(RATIO);
    localparam int LW = $clog2(RATIO) + 1;
    // A zero-width idle counter is illegal, so keep one bit when disabled.
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [RATIO-2:0][W-1:0] acc;
    logic [FW-1:0]           fill;
    logic                    pending;
    logic [IW-1:0]           idle;

    logic                    out_free;
    logic                    accept;
    logic                    complete;
    logic                    timeout_hit;
    logic                    flush_req;
    logic                    partial;
    logic                    emit;
    logic [RATIO*W-1:0]      word;

    assign out_free    = !sender.valid || sender.ready;
    // Only a full accumulator waits on the output; depends on sender.ready,
    // never on receiver.valid.
    assign receiver.ready = (fill < FW'(RATIO - 1)) || out_free;
    assign accept      = receiver.valid && receiver.ready;
    assign complete    = accept && (fill == FW'(RATIO - 1));
    assign timeout_hit = (TIMEOUT > 0) && (idle == IW'(TIMEOUT));
    assign flush_req   = pending || flush || timeout_hit;
    assign partial     = out_free && flush_req && !complete && (fill != '0 || accept);
    assign emit        = complete || partial;

    // Outgoing word: filled lanes, the incoming beat in lane `fill` when it
    // is accepted, zeros above. A full word is the same with fill = RATIO-1.
    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (i < int'(fill)) word[i*W +: W] = acc[i];
        end
        if (accept) word[int'(fill)*W +: W] = receiver.data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sender.valid <= 1'b0;
            sender.data  <= '0;
            lanes        <= '0;
            acc          <= '0;
            fill         <= '0;
            pending      <= 1'b0;
            idle         <= '0;
        end else begin
            if (emit) begin
                sender.valid <= 1'b1;
                sender.data  <= word;
                lanes        <= LW'(fill) + LW'(accept);
                acc          <= '0;
                fill         <= '0;
                pending      <= 1'b0;
            end else begin
                if (sender.ready) sender.valid <= 1'b0;
                if (accept) begin
                    acc[fill] <= receiver.data;
                    fill      <= fill + FW'(1);
                end
                // Nothing to emit clears the request; otherwise it can only
                // be here because the output is blocked, so hold it.
                pending <= flush_req && (fill != '0 || accept);
            end

            if (TIMEOUT > 0) begin
                if (accept || emit || fill == '0) idle <= '0;
                else if (idle != IW'(TIMEOUT))    idle <= idle + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_stream_pack.sv
module tb_stream_pack;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush0 = 1'b0, flush1 = 1'b0;
    logic [2:0] lanes0, lanes1;
    int errors = 0;
    int checks = 0;

    stream #(.T(logic [31:0]))  rx0 ();
    stream #(.T(logic [127:0])) tx0 ();
    stream #(.T(logic [31:0]))  rx1 ();
    stream #(.T(logic [127:0])) tx1 ();

    stream_pack #(.T(logic [31:0]), .RATIO(4), .TIMEOUT(0)) dut0 (
        .clock(clock), .reset(reset), .receiver(rx0), .sender(tx0),
        .flush(flush0), .lanes(lanes0));
    stream_pack #(.T(logic [31:0]), .RATIO(4), .TIMEOUT(5)) dut1 (
        .clock(clock), .reset(reset), .receiver(rx1), .sender(tx1),
        .flush(flush1), .lanes(lanes1));

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        rx0.valid = 0; rx1.valid = 0; flush0 = 0; flush1 = 0;
        rx0.data = '0; rx1.data = '0;
        reset = 1; tick; tick; reset = 0;
    endtask

    function automatic logic [127:0] mk(input logic [31:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic send0(input logic [31:0] d);
        rx0.valid = 1; rx0.data = d; tick; rx0.valid = 0;
    endtask

    task automatic test_reset;
        rx0.valid = 0; tx0.ready = 0; rx1.valid = 0; tx1.ready = 0;
        reset = 1; tick; tick;
        checks++; if (tx0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tx0.valid); end
        checks++; if (lanes0 !== 3'd0) begin errors++; $display("FAIL reset_lanes got %0d want 0", lanes0); end
        checks++; if (tx0.data !== 128'd0) begin errors++; $display("FAIL reset_data got %h want 0", tx0.data); end
        checks++; if (rx0.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rx0.ready); end
        reset = 0;
    endtask

    task automatic test_throughput;
        logic [31:0] b [8];
        logic [127:0] w;
        do_reset; tx0.ready = 1;
        for (int i = 0; i < 8; i++) begin
            b[i] = 32'h11 * (i + 1);
            rx0.valid = 1; rx0.data = b[i]; #1;
            checks++; if (rx0.ready !== 1'b1) begin errors++; $display("FAIL tput_ready beat %0d got %b want 1", i, rx0.ready); end
            tick;
            if (i == 3 || i == 7) begin
                w = (i == 3) ? mk(b[0], b[1], b[2], b[3]) : mk(b[4], b[5], b[6], b[7]);
                checks++; if (tx0.valid !== 1'b1) begin errors++; $display("FAIL tput_valid beat %0d got %b want 1", i, tx0.valid); end
                checks++; if (tx0.data !== w) begin errors++; $display("FAIL tput_data beat %0d got %h want %h", i, tx0.data, w); end
                checks++; if (lanes0 !== 3'd4) begin errors++; $display("FAIL tput_lanes got %0d want 4", lanes0); end
            end else begin
                checks++; if (tx0.valid !== 1'b0) begin errors++; $display("FAIL tput_idle beat %0d got %b want 0", i, tx0.valid); end
            end
        end
        rx0.valid = 0; tick;
    endtask

    task automatic test_backpressure;
        logic [31:0] b [10];
        int k = 0;
        logic took;
        for (int i = 0; i < 10; i++) b[i] = 32'h100 + i;
        do_reset; tx0.ready = 0;
        for (int c = 0; c < 10; c++) begin
            rx0.valid = 1; rx0.data = b[k]; #1;
            took = rx0.ready;
            tick;
            if (took) k++;
            if (k >= 4) begin
                checks++;
                if (tx0.valid !== 1'b1 || tx0.data !== mk(b[0], b[1], b[2], b[3]) || lanes0 !== 3'd4) begin
                    errors++; $display("FAIL bp_hold cycle %0d got %b/%h/%0d want 1/%h/4", c, tx0.valid, tx0.data, lanes0, mk(b[0], b[1], b[2], b[3]));
                end
            end
        end
        checks++; if (k !== 7) begin errors++; $display("FAIL bp_accepted got %0d want 7", k); end
        rx0.data = b[k]; #1;
        checks++; if (rx0.ready !== 1'b0) begin errors++; $display("FAIL bp_stall got %b want 0", rx0.ready); end
        tx0.ready = 1; #1;
        checks++; if (rx0.ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", rx0.ready); end
        tick; rx0.valid = 0;
        checks++; if (tx0.valid !== 1'b1 || tx0.data !== mk(b[4], b[5], b[6], b[7]) || lanes0 !== 3'd4) begin
            errors++; $display("FAIL bp_next got %b/%h/%0d want 1/%h/4", tx0.valid, tx0.data, lanes0, mk(b[4], b[5], b[6], b[7]));
        end
        tick;
        checks++; if (tx0.valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", tx0.valid); end
    endtask

    task automatic test_flush;
        do_reset; tx0.ready = 1;
        send0(32'hA); send0(32'hB);
        flush0 = 1; tick; flush0 = 0;
        checks++; if (tx0.valid !== 1'b1 || tx0.data !== mk(32'hA, 32'hB, 0, 0) || lanes0 !== 3'd2) begin
            errors++; $display("FAIL flush_word got %b/%h/%0d want 1/%h/2", tx0.valid, tx0.data, lanes0, mk(32'hA, 32'hB, 0, 0));
        end
        tick;
        flush0 = 1; tick; flush0 = 0;
        checks++; if (tx0.valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", tx0.valid); end
        tick;
        checks++; if (tx0.valid !== 1'b0) begin errors++; $display("FAIL flush_empty_late got %b want 0", tx0.valid); end
    endtask

    task automatic test_flush_accept;
        int seen = 0;
        do_reset; tx0.ready = 1;
        send0(32'h5);
        rx0.valid = 1; rx0.data = 32'hC; flush0 = 1; tick; rx0.valid = 0; flush0 = 0;
        checks++; if (tx0.valid !== 1'b1 || tx0.data !== mk(32'h5, 32'hC, 0, 0) || lanes0 !== 3'd2) begin
            errors++; $display("FAIL flacc_word got %b/%h/%0d want 1/%h/2", tx0.valid, tx0.data, lanes0, mk(32'h5, 32'hC, 0, 0));
        end
        // flush requested while a full word sits blocked on the output
        do_reset; tx0.ready = 0;
        send0(32'h1); send0(32'h2); send0(32'h3); send0(32'h4);
        send0(32'hD);
        flush0 = 1; tick; flush0 = 0;
        send0(32'hE);
        tick; tick; tick;
        checks++; if (tx0.valid !== 1'b1 || tx0.data !== mk(1, 2, 3, 4)) begin
            errors++; $display("FAIL flblk_hold got %b/%h want 1/%h", tx0.valid, tx0.data, mk(1, 2, 3, 4));
        end
        tx0.ready = 1; tick;
        checks++; if (tx0.valid !== 1'b1 || tx0.data !== mk(32'hD, 32'hE, 0, 0) || lanes0 !== 3'd2) begin
            errors++; $display("FAIL flblk_word got %b/%h/%0d want 1/%h/2", tx0.valid, tx0.data, lanes0, mk(32'hD, 32'hE, 0, 0));
        end
        repeat (6) begin tick; if (tx0.valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flblk_extra got %0d words want 0", seen); end
    endtask

    task automatic test_timeout;
        int n = 0;
        int seen = 0;
        do_reset; tx1.ready = 1;
        for (int i = 0; i < 3; i++) begin rx1.valid = 1; rx1.data = 32'h70 + i; tick; end
        rx1.valid = 0;
        while (!tx1.valid && n < 20) begin tick; n++; end
        checks++; if (n !== 6) begin errors++; $display("FAIL timeout_delay got %0d want 6", n); end
        checks++; if (tx1.data !== mk(32'h70, 32'h71, 32'h72, 0) || lanes1 !== 3'd3) begin
            errors++; $display("FAIL timeout_word got %h/%0d want %h/3", tx1.data, lanes1, mk(32'h70, 32'h71, 32'h72, 0));
        end
        tx1.ready = 0;
        do_reset; tx0.ready = 1;
        send0(32'h1); send0(32'h2); send0(32'h3);
        repeat (100) begin tick; if (tx0.valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL no_timeout got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_mid;
        do_reset; tx0.ready = 0;
        for (int i = 0; i < 6; i++) send0(32'h200 + i);
        reset = 1; tick;
        checks++; if (tx0.valid !== 1'b0 || lanes0 !== 3'd0) begin
            errors++; $display("FAIL rmid_clear got %b/%0d want 0/0", tx0.valid, lanes0);
        end
        reset = 0; tx0.ready = 1;
        for (int i = 0; i < 3; i++) send0(32'h300 + i);
        checks++; if (tx0.valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got %b want 0", tx0.valid); end
        send0(32'h303);
        checks++; if (tx0.valid !== 1'b1 || tx0.data !== mk(32'h300, 32'h301, 32'h302, 32'h303) || lanes0 !== 3'd4) begin
            errors++; $display("FAIL rmid_word got %b/%h/%0d want 1/%h/4", tx0.valid, tx0.data, lanes0, mk(32'h300, 32'h301, 32'h302, 32'h303));
        end
    endtask

    // Reference: beats collect in arrival order; every fourth beat closes a
    // word, and words leave in order whenever the output handshakes.
    task automatic test_random;
        logic [31:0]  pend [$];
        logic [127:0] expq [$];
        logic [127:0] w;
        logic want_ready, acc, fire;
        int words = 0;
        do_reset;
        for (int c = 0; c < 600; c++) begin
            rx0.valid = ($urandom_range(9) < 7);
            rx0.data  = $urandom;
            tx0.ready = (c >= 560) || ($urandom_range(9) < 6);
            if (c >= 560) rx0.valid = 0;
            #1;
            want_ready = !(pend.size() == 3 && tx0.valid && !tx0.ready);
            checks++; if (rx0.ready !== want_ready) begin errors++; $display("FAIL rand_ready cycle %0d got %b want %b", c, rx0.ready, want_ready); end
            acc  = rx0.valid && rx0.ready;
            fire = tx0.valid && tx0.ready;
            if (fire) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rand_extra cycle %0d got %h want none", c, tx0.data);
                end else begin
                    w = expq.pop_front();
                    words++;
                    if (tx0.data !== w || lanes0 !== 3'd4) begin
                        errors++; $display("FAIL rand_word cycle %0d got %h/%0d want %h/4", c, tx0.data, lanes0, w);
                    end
                end
            end
            if (acc) begin
                pend.push_back(rx0.data);
                if (pend.size() == 4) begin
                    expq.push_back(mk(pend[0], pend[1], pend[2], pend[3]));
                    pend.delete();
                end
            end
            tick;
        end
        checks++; if (expq.size() != 0 || words < 20) begin
            errors++; $display("FAIL rand_count got %0d words left %0d want left 0", words, expq.size());
        end
    endtask

    initial begin
        rx0.valid = 0; rx0.data = '0; tx0.ready = 0;
        rx1.valid = 0; rx1.data = '0; tx1.ready = 0;
        test_reset;
        test_throughput;
        test_backpressure;
        test_flush;
        test_flush_accept;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
